// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
// Four-digit, time-multiplexed seven-segment driver for a common-anode display.
// A prescaler divides clk into digit slots of CLK_DIV cycles. A 2-bit index
// walks the digits 0->1->2->3->0. The first BLANK_CYCLES cycles of each slot
// keep every anode off to suppress ghosting.
// The displayed value and decimal points come from shadow registers. These
// reload only at frame boundaries, so a frame never mixes two input values.
// While the driver is disabled the shadows follow the inputs every cycle.
//
// Optional build macro:
//   SEG7_LZ_BLANK_EN  - leading-zero blanking. Digits 3..1 stay dark when they
//                       and every more-significant digit are zero. Digit 0 is
//                       always shown.
//
// All pin outputs are registered. Pins show the slot and guard state of the
// previous cycle, so each slot appears on the pins one cycle after the
// prescaler enters it. The slot length is unchanged.

module seg7_scan_mux #(
    parameter int unsigned CLK_DIV      = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GUARD_LEN     = GW'(BLANK_CYCLES);

    logic [PW-1:0] prescaler;
    logic [GW-1:0] guardCnt;
    logic [1:0]    idx;
    logic [15:0]   shadowValue;
    logic [3:0]    shadowDp;

    logic          slotEnd;
    logic          tick;
    logic          frameTick;
    logic          inGuard;
    logic          suppress;
    logic          drive;
    logic [3:0]    currentDigit;

    logic [3:0]    anNext;
    logic [6:0]    segNext;
    logic          dpNext;

    // Hex digit to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decodeHex(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'h0:    pattern = 7'b1000000;
            4'h1:    pattern = 7'b1111001;
            4'h2:    pattern = 7'b0100100;
            4'h3:    pattern = 7'b0110000;
            4'h4:    pattern = 7'b0011001;
            4'h5:    pattern = 7'b0010010;
            4'h6:    pattern = 7'b0000010;
            4'h7:    pattern = 7'b1111000;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0010000;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b0000011;
            4'hC:    pattern = 7'b1000110;
            4'hD:    pattern = 7'b0100001;
            4'hE:    pattern = 7'b0000110;
            default: pattern = 7'b0001110;
        endcase
        return pattern;
    endfunction

    // Slot timing strobes: a tick ends a slot, and a tick on digit 3 ends the frame.
    always_comb begin
        slotEnd   = (prescaler == PRESCALE_LAST);
        tick      = slotEnd && enable;
        frameTick = tick && (idx == 2'd3);
        inGuard   = (guardCnt < GUARD_LEN);
    end

    // Slot prescaler: counts cycles within a slot and parks at zero while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (!enable || slotEnd) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Guard counter: counts the blanked cycles at the start of a slot and saturates at the guard length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guardCnt <= '0;
        end else if (!enable || tick) begin
            guardCnt <= '0;
        end else if (inGuard) begin
            guardCnt <= guardCnt + GW'(1);
        end
    end

    // Digit index: steps to the next digit on each tick and restarts at digit 0 while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= 2'd0;
        end else if (!enable) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // Shadow registers: reload at each frame boundary, and every cycle while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadowValue <= 16'h0000;
            shadowDp    <= 4'h0;
        end else if (!enable || frameTick) begin
            shadowValue <= value;
            shadowDp    <= dp_in;
        end
    end

    // Pick the shadow digit for the current slot.
    always_comb begin
        currentDigit = 4'h0;
        case (idx)
            2'd0:    currentDigit = shadowValue[3:0];
            2'd1:    currentDigit = shadowValue[7:4];
            2'd2:    currentDigit = shadowValue[11:8];
            default: currentDigit = shadowValue[15:12];
        endcase
    end

`ifdef SEG7_LZ_BLANK_EN
    // Leading-zero suppression: a digit stays dark when it and all more-significant digits are zero.
    always_comb begin
        suppress = 1'b0;
        case (idx)
            2'd3:    suppress = (shadowValue[15:12] == 4'h0);
            2'd2:    suppress = (shadowValue[15:8] == 8'h00);
            2'd1:    suppress = (shadowValue[15:4] == 12'h000);
            default: suppress = 1'b0;
        endcase
    end
`else
    assign suppress = 1'b0;
`endif

    // Next pin values: dark unless scanning, past the guard and not suppressed.
    always_comb begin
        drive   = enable && !inGuard && !suppress;
        anNext  = 4'b1111;
        segNext = 7'h7F;
        dpNext  = 1'b1;
        if (drive) begin
            anNext  = ~(4'b0001 << idx);
            segNext = decodeHex(currentDigit);
            dpNext  = ~shadowDp[idx];
        end
    end

    // Output registers: reset forces the pins dark at once, independent of the clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= anNext;
            seg        <= segNext;
            dp         <= dpNext;
            frame_done <= frameTick;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux
// Directed bench for seg7_scan_mux with CLK_DIV=8 and BLANK_CYCLES=2.
// A cycle-level model predicts the pins from elapsed scan time and the latched
// frame value. It is compared on every falling edge. Hand-computed pin values
// at chosen cycles pin the model itself.
// Honours SEG7_LZ_BLANK_EN when it is defined for the build.

module tb_seg7_scan_mux;

    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] value  = 16'h0000;
    logic [3:0]  dpIn   = 4'h0;

    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frameDone;

    int vectorCount = 0;
    int missCount   = 0;
    bit checkOn     = 1'b0;

    // Model state: cycles since the current scan started, and the latched frame contents.
    int          scanTime  = 0;
    logic [15:0] shown     = 16'h0000;
    logic [3:0]  shownDp   = 4'h0;
    logic [3:0]  expAn     = 4'hF;
    logic [6:0]  expSeg    = 7'h7F;
    logic        expDp     = 1'b1;
    logic        expFrame  = 1'b0;

    int          mCycle;
    logic [1:0]  mSlot;
    logic [3:0]  mDigit;
    logic        mSuppress;
    logic        mLit;
    logic        mFrameEnd;
    logic [3:0]  mAn;
    logic [6:0]  mSeg;
    logic        mDp;

    seg7_scan_mux #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .dp_in      (dpIn),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frameDone)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Model view of the current cycle: which slot, how far into it, and what it should show.
    always_comb begin
        mCycle    = scanTime % CLK_DIV;
        mSlot     = 2'((scanTime / CLK_DIV) % 4);
        mDigit    = 4'(shown >> (4 * int'(mSlot)));
        mSuppress = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        mSuppress = (mSlot != 2'd0) && ((shown >> (4 * int'(mSlot))) == 16'h0000);
`endif
        mLit      = enable && (mCycle >= BLANK_CYCLES) && !mSuppress;
        mFrameEnd = enable && (mSlot == 2'd3) && (mCycle == CLK_DIV - 1);
        mAn       = 4'hF;
        mSeg      = 7'h7F;
        mDp       = 1'b1;
        if (mLit) begin
            mAn[mSlot] = 1'b0;
            mSeg       = GLYPH[mDigit];
            mDp        = ~shownDp[mSlot];
        end
    end

    // Model clocking: pins take this cycle's prediction; time and frame contents advance.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            scanTime <= 0;
            shown    <= 16'h0000;
            shownDp  <= 4'h0;
            expAn    <= 4'hF;
            expSeg   <= 7'h7F;
            expDp    <= 1'b1;
            expFrame <= 1'b0;
        end else begin
            expAn    <= mAn;
            expSeg   <= mSeg;
            expDp    <= mDp;
            expFrame <= mFrameEnd;
            if (!enable) begin
                scanTime <= 0;
                shown    <= value;
                shownDp  <= dpIn;
            end else begin
                scanTime <= scanTime + 1;
                if (mFrameEnd) begin
                    shown   <= value;
                    shownDp <= dpIn;
                end
            end
        end
    end

    // Every-cycle comparison of the DUT pins against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkOn) begin
            vectorCount = vectorCount + 1;
            if (an !== expAn || seg !== expSeg || dp !== expDp || frameDone !== expFrame) begin
                missCount = missCount + 1;
                $display("[TB] FAIL model-compare t=%0t got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frameDone, expAn, expSeg, expDp, expFrame);
            end
        end
    end

    task automatic applyStimulus(input logic en, input logic [15:0] val, input logic [3:0] dpv);
        enable = en;
        value  = val;
        dpIn   = dpv;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eAn, input logic [6:0] eSeg,
                               input logic eDp, input logic eFd);
        vectorCount = vectorCount + 1;
        if (an !== eAn || seg !== eSeg || dp !== eDp || frameDone !== eFd) begin
            missCount = missCount + 1;
            $display("[TB] FAIL %s t=%0t got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                     name, $time, an, seg, dp, frameDone, eAn, eSeg, eDp, eFd);
        end
    endtask

    task automatic checkDark(input string name);
        checkOutput(name, 4'b1111, 7'h7F, 1'b1, 1'b0);
    endtask

    // Directed scenario sequence with hand-computed pin values.
    initial begin
        #2 reset = 1'b1;
        waitCycles(2);
        checkOn = 1'b1;
        waitCycles(1);
        checkDark("reset-state");

        // Release with enable low so the shadow picks up 1234 before scanning.
        applyStimulus(1'b0, 16'h1234, 4'b0000);
        reset = 1'b0;
        waitCycles(1);
        applyStimulus(1'b1, 16'h1234, 4'b0000);

        waitCycles(1);  checkDark("slot0-guard");
        waitCycles(2);  checkOutput("digit0-4", 4'b1110, 7'b0011001, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("digit1-3", 4'b1101, 7'b0110000, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("digit2-2", 4'b1011, 7'b0100100, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("digit3-1", 4'b0111, 7'b1111001, 1'b1, 1'b0);
        waitCycles(5);  checkOutput("frame-done", 4'b0111, 7'b1111001, 1'b1, 1'b1);
        waitCycles(1);  checkDark("next-frame-guard");

        // Change value during the digit-1 slot; it must wait for the frame boundary.
        waitCycles(11); applyStimulus(1'b1, 16'hABCD, 4'b0000);
        waitCycles(7);  checkOutput("old-digit2", 4'b1011, 7'b0100100, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("old-digit3", 4'b0111, 7'b1111001, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("new-digit0-d", 4'b1110, 7'b0100001, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("new-digit1-C", 4'b1101, 7'b1000110, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("new-digit2-b", 4'b1011, 7'b0000011, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("new-digit3-A", 4'b0111, 7'b0001000, 1'b1, 1'b0);

        // Decimal points on digits 0 and 2.
        applyStimulus(1'b1, 16'hABCD, 4'b0101);
        waitCycles(8);  checkOutput("dp-digit0", 4'b1110, 7'b0100001, 1'b0, 1'b0);
        waitCycles(8);  checkOutput("dp-digit1", 4'b1101, 7'b1000110, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("dp-digit2", 4'b1011, 7'b0000011, 1'b0, 1'b0);
        waitCycles(8);  checkOutput("dp-digit3", 4'b0111, 7'b0001000, 1'b1, 1'b0);

        // Drop enable mid-slot, present 0009, then re-enable.
        waitCycles(2);  applyStimulus(1'b0, 16'h0009, 4'b0000);
        waitCycles(1);  checkDark("disabled-first");
        waitCycles(4);  checkDark("disabled-hold");
        applyStimulus(1'b1, 16'h0009, 4'b0000);
        waitCycles(1);  checkDark("reenable-guard");
        waitCycles(2);  checkOutput("reenable-digit0-9", 4'b1110, 7'b0010000, 1'b1, 1'b0);
`ifdef SEG7_LZ_BLANK_EN
        waitCycles(8);  checkDark("lz-digit1-0009");
        waitCycles(10); checkDark("lz-digit2-0009");
`else
        waitCycles(8);  checkOutput("digit1-0009", 4'b1101, 7'b1000000, 1'b1, 1'b0);
        waitCycles(10); checkOutput("digit2-0009", 4'b1011, 7'b1000000, 1'b1, 1'b0);
`endif

        // Asynchronous reset at slot cycle 5 of digit 2.
        reset = 1'b1;
        #1 checkDark("async-reset");
        waitCycles(1);
        reset = 1'b0;
        waitCycles(3);  checkOutput("post-reset-digit0", 4'b1110, 7'b1000000, 1'b1, 1'b0);

        // Leading-zero pattern 0040, then all zeros.
        applyStimulus(1'b1, 16'h0040, 4'b0000);
        waitCycles(32); checkOutput("0040-digit0", 4'b1110, 7'b1000000, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("0040-digit1", 4'b1101, 7'b0011001, 1'b1, 1'b0);
`ifdef SEG7_LZ_BLANK_EN
        waitCycles(8);  checkDark("lz-0040-digit2");
        waitCycles(8);  checkDark("lz-0040-digit3");
`else
        waitCycles(8);  checkOutput("0040-digit2", 4'b1011, 7'b1000000, 1'b1, 1'b0);
        waitCycles(8);  checkOutput("0040-digit3", 4'b0111, 7'b1000000, 1'b1, 1'b0);
`endif
        applyStimulus(1'b1, 16'h0000, 4'b0000);
        waitCycles(8);  checkOutput("zero-digit0", 4'b1110, 7'b1000000, 1'b1, 1'b0);
`ifdef SEG7_LZ_BLANK_EN
        waitCycles(8);  checkDark("lz-zero-digit1");
`else
        waitCycles(8);  checkOutput("zero-digit1", 4'b1101, 7'b1000000, 1'b1, 1'b0);
`endif
        waitCycles(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Four-digit, time-multiplexed seven-segment display driver that consumes a 16-bit hex value and scans it onto a common-anode display. It contains its own scan prescaler and 2-bit digit-index counter, which advances 0→1→2→3→0. It sits downstream of the counter/datapath stages and drives the board display pins directly. A frame-aligned shadow register keeps each displayed frame coherent.

## Interface
- CLK_DIV, 100000: clk cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 16: anode-off guard cycles at the start of each slot, for ghost suppression; must be < CLK_DIV; 0 disables the guard.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- enable  input  1  1 = scanning; 0 = display dark.
- value  input  16  four hex digits; digit i = value[4i+3:4i].
- dp_in  input  4  decimal point request per digit; 1 = lit.
- an  output  4  anode selects, active-low, one-hot-low when driving.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse at each frame boundary.

## Operation
- Reset values: an=4'b1111, seg=7'h7F, dp=1, frame_done=0, idx=0, prescaler=0, guard counter=0, shadow=16'h0000.
- Prescaler counts 0..CLK_DIV-1 and wraps. tick = (prescaler==CLK_DIV-1) && enable.
- On tick, idx advances modulo 4 and the guard counter restarts.
- Frame boundary is a tick with idx==3:
  - value and dp_in load into the shadow registers;
  - frame_done pulses for the next cycle.
- While enable=0:
  - prescaler, guard counter and idx are held at 0;
  - the shadow registers load every cycle, so they are transparent;
  - an=1111, seg=7F, dp=1.
- Digit decode (hex, gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- During a slot's guard cycles: an=1111, seg=7F, dp=1.
- During the remaining cycles of the slot:
  - an[idx]=0;
  - seg = decode(shadow digit idx);
  - dp = ~shadow_dp[idx].
- All outputs are registered; there are no combinational paths from inputs to pins.

## Timing
- Slot cycle 0 is the first cycle after reset release, after enable rising, or after a tick.
- Slot cycles 0..BLANK_CYCLES-1 are blanked. Cycles BLANK_CYCLES..CLK_DIV-1 drive digit idx.
- Slot length is exactly CLK_DIV cycles; frame length is 4·CLK_DIV cycles.
- Registered-output latency: an/seg/dp reflect the idx and guard state one cycle after that state is computed. The bench compares against pin values, which include this cycle.
- value changes mid-frame have no visible effect until the next frame boundary.
- Reset asserted mid-slot: all outputs go to reset values immediately (asynchronously). Scanning restarts at digit 0, slot cycle 0, after release.
- enable deasserted mid-slot: pins are dark from the next cycle. On re-enable, scanning starts at digit 0 with the value sampled on the last disabled cycle.
- frame_done never asserts while enable=0.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking.
  - Digit k (k=3..1) is suppressed when shadow digits k..3 are all zero. During a suppressed slot, an stays 1111 for the whole slot.
  - Digit 0 is always shown, and dp_in does not override the suppression.
- SEG7_LZ_BLANK_EN undefined: all four digits are always displayed.

## Test plan
All scenarios use CLK_DIV=8 and BLANK_CYCLES=2.
- value=16'h1234, dp_in=0, enable=1, run two frames → per slot, 2 cycles of an=1111, then 6 cycles of: an=1110/seg=0011001, an=1101/seg=0110000, an=1011/seg=0100100, an=0111/seg=1111001. frame_done pulses every 32 cycles.
- Change value from 1234 to ABCD during the digit-1 slot → digits 2 and 3 still show 2 and 1. The next frame shows d=0100001, C=1000110, b=0000011, A=0001000.
- dp_in=4'b0101 → dp=0 only during the driven cycles of the digit-0 and digit-2 slots, otherwise 1.
- enable dropped mid-slot, value set to 16'h0009, enable raised → an=1111/seg=7F while disabled. First driven slot is digit 0 with seg=0010000, after 2 guard cycles.
- Reset pulsed at slot cycle 5 of digit 2 → an=1111, seg=7F, dp=1 in the same cycle. After release, digit 0 is driven at cycle 2.
- SEG7_LZ_BLANK_EN, value=16'h0040 → digit 3 and digit 2 slots are fully dark; digit 1 shows 4 and digit 0 shows 0. value=0 → only digit 0 is lit, with 0. Without the macro, 16'h0040 shows 0,0,4,0.
